// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit geometry, credit depth and the VC index width helper.
package noc_pkg;

  localparam int DATA_W_DEF   = 20;
  localparam int NUM_VC_DEF   = 2;
  localparam int CREDITS_DEF  = 4;
  localparam int TX_DEPTH_DEF = 4;

  // Buffered flits are stored as {vc, data}; data sits at the bottom.
  localparam int FLIT_DATA_LSB = 0;

  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

endpackage

// File: rtl/pe_credit_node_if.sv
// Bus bundle between a PE endpoint and its environment (local source/sink and router port).
interface pe_credit_node_if
  import noc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_VC = NUM_VC_DEF
);
  localparam int VC_W = vc_width(NUM_VC);

  logic [DATA_W-1:0] src_data;
  logic [VC_W-1:0]   src_vc;
  logic              src_valid;
  logic              src_ready;

  logic [DATA_W-1:0] dataout;
  logic [VC_W-1:0]   out_vc;
  logic              out_valid;
  logic [NUM_VC-1:0] ci;

  logic [DATA_W-1:0] datain;
  logic [VC_W-1:0]   in_vc;
  logic              in_valid;
  logic [NUM_VC-1:0] co;

  logic [DATA_W-1:0] sink_data;
  logic [VC_W-1:0]   sink_vc;
  logic              sink_valid;
  logic              sink_ready;

  logic              err_credit;
  logic              err_ovf;
  logic [15:0]       tx_cnt;
  logic [15:0]       rx_cnt;

  // master: the PE node itself; slave: the surrounding source, sink and router.
  modport master (
    input  src_data, src_vc, src_valid, ci, datain, in_vc, in_valid, sink_ready,
    output src_ready, dataout, out_vc, out_valid, co, sink_data, sink_vc, sink_valid,
           err_credit, err_ovf, tx_cnt, rx_cnt
  );

  modport slave (
    output src_data, src_vc, src_valid, ci, datain, in_vc, in_valid, sink_ready,
    input  src_ready, dataout, out_vc, out_valid, co, sink_data, sink_vc, sink_valid,
           err_credit, err_ovf, tx_cnt, rx_cnt
  );

endinterface

// File: rtl/pe_sync_fifo.sv
// Synchronous FIFO with show-ahead head output; a push into a full FIFO is taken when a pop frees a slot.
module pe_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = $clog2(DEPTH + 1);

  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CNW-1:0] count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_next(wptr);
      if (do_pop)  rptr <= ptr_next(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/pe_credit_node.sv
// NoC PE endpoint: credit-controlled injection toward the router, buffered ejection to the local sink.
module pe_credit_node
  import noc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_VC   = NUM_VC_DEF,
  parameter int CREDITS  = CREDITS_DEF,
  parameter int TX_DEPTH = TX_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              RST,
  pe_credit_node_if.master  bus
);

  localparam int VC_W     = vc_width(NUM_VC);
  localparam int FW       = VC_W + DATA_W;
  localparam int CW       = $clog2(CREDITS + 1);
  localparam int RX_DEPTH = NUM_VC * CREDITS;

  logic [FW-1:0]     tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic [VC_W-1:0]   head_vc;
  logic              send;

  logic [FW-1:0]     rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_pop;
  logic              rx_accept;
  logic [VC_W-1:0]   rx_head_vc;

  logic [NUM_VC-1:0][CW-1:0] cred_q;
  logic [NUM_VC-1:0][CW-1:0] cred_d;
  logic                      credit_err_set;

  logic [DATA_W-1:0] dataout_p1;
  logic [VC_W-1:0]   out_vc_p1;
  logic              vld_p1;
  logic [NUM_VC-1:0] co_p1;
  logic              err_credit_q;
  logic              err_ovf_q;
  logic [15:0]       tx_cnt_q;
  logic [15:0]       rx_cnt_q;

  function automatic logic [CW-1:0] cred_next(input logic [CW-1:0] c, input logic dec,
                                              input logic inc);
    if (dec && !inc)               return c - 1'b1;
    if (inc && !dec && c != CW'(CREDITS)) return c + 1'b1;
    return c;
  endfunction

  assign tx_push = bus.src_valid && !tx_full;
  assign head_vc = tx_head[FW-1 -: VC_W];
  // A head without credit stalls everything behind it; flits never overtake each other.
  assign send    = !tx_empty && (cred_q[head_vc] != '0);

  pe_sync_fifo #(.W(FW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (RST),
    .push  (tx_push),
    .pop   (send),
    .wdata ({bus.src_vc, bus.src_data}),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    cred_d         = cred_q;
    credit_err_set = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      cred_d[v] = cred_next(cred_q[v], send && (head_vc == VC_W'(v)), bus.ci[v]);
      if (bus.ci[v] && !(send && (head_vc == VC_W'(v))) && cred_q[v] == CW'(CREDITS))
        credit_err_set = 1'b1;
    end
  end

  assign rx_pop     = !rx_empty && bus.sink_ready;
  assign rx_accept  = bus.in_valid && (!rx_full || rx_pop);
  assign rx_head_vc = rx_head[FW-1 -: VC_W];

  pe_sync_fifo #(.W(FW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (RST),
    .push  (bus.in_valid),
    .pop   (rx_pop),
    .wdata ({bus.in_vc, bus.datain}),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Stage p1: registered router-side outputs, credit state, co pulses and statistics.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= CW'(CREDITS);
      dataout_p1   <= '0;
      out_vc_p1    <= '0;
      vld_p1       <= 1'b0;
      co_p1        <= '0;
      err_credit_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
    end else begin
      cred_q <= cred_d;
      vld_p1 <= send;
      if (send) begin
        dataout_p1 <= tx_head[FLIT_DATA_LSB +: DATA_W];
        out_vc_p1  <= head_vc;
        tx_cnt_q   <= tx_cnt_q + 16'd1;
      end
      co_p1 <= rx_pop ? (NUM_VC'(1) << rx_head_vc) : '0;
      if (rx_accept) rx_cnt_q <= rx_cnt_q + 16'd1;
      if (credit_err_set) err_credit_q <= 1'b1;
      if (bus.in_valid && !rx_accept) err_ovf_q <= 1'b1;
    end
  end

  assign bus.src_ready  = !tx_full;
  assign bus.dataout    = dataout_p1;
  assign bus.out_vc     = out_vc_p1;
  assign bus.out_valid  = vld_p1;
  assign bus.co         = co_p1;
  assign bus.sink_valid = !rx_empty;
  assign bus.sink_data  = rx_empty ? '0 : rx_head[FLIT_DATA_LSB +: DATA_W];
  assign bus.sink_vc    = rx_empty ? '0 : rx_head_vc;
  assign bus.err_credit = err_credit_q;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.tx_cnt     = tx_cnt_q;
  assign bus.rx_cnt     = rx_cnt_q;

endmodule

// File: tb/tb_pe_credit_node.sv
// Directed bench for pe_credit_node: credit flow, HOL blocking, RX overflow, co pulses, reset.
module tb_pe_credit_node;

  logic clk = 1'b0;
  logic RST = 1'b1;
  int   total  = 0;
  int   passed = 0;

  pe_credit_node_if #(.DATA_W(20), .NUM_VC(2)) bus ();

  pe_credit_node #(.DATA_W(20), .NUM_VC(2), .CREDITS(4), .TX_DEPTH(4)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [10:0] ov;
  logic [19:0] last_data;

  initial begin
    bus.src_data = '0; bus.src_vc = '0; bus.src_valid = 1'b0; bus.ci = '0;
    bus.datain = '0; bus.in_vc = '0; bus.in_valid = 1'b0; bus.sink_ready = 1'b0;
    last_data = '0;
    ov = '0;

    step(); step();
    RST = 1'b0;
    chk("rst_src_ready", bus.src_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dataout", bus.dataout, 0);
    chk("rst_sink_valid", bus.sink_valid, 0);
    chk("rst_co", bus.co, 0);
    chk("rst_errs", {bus.err_credit, bus.err_ovf}, 0);
    chk("rst_cred0", dut.cred_q[0], 4);
    chk("rst_cred1", dut.cred_q[1], 4);

    // 1: five flits on VC0 with no credit return
    for (int i = 0; i < 11; i++) begin
      bus.src_valid = (i < 5);
      bus.src_data  = 20'h100 + 20'(i);
      bus.src_vc    = 1'b0;
      step();
      ov[i] = bus.out_valid;
      if (bus.out_valid) last_data = bus.dataout;
    end
    bus.src_valid = 1'b0;
    chk("t1_pulse_pattern", 32'(ov), 32'b00000011110);
    chk("t1_last_data", last_data, 20'h103);
    chk("t1_tx_cnt", bus.tx_cnt, 4);
    chk("t1_src_ready", bus.src_ready, 1);
    chk("t1_cred0", dut.cred_q[0], 0);

    // 2: one credit releases the held fifth flit
    bus.ci = 2'b01;
    step();
    bus.ci = 2'b00;
    chk("t2_not_yet", bus.out_valid, 0);
    chk("t2_cred0_one", dut.cred_q[0], 1);
    step();
    chk("t2_out_valid", bus.out_valid, 1);
    chk("t2_dataout", bus.dataout, 20'h104);
    chk("t2_cred0_zero", dut.cred_q[0], 0);
    chk("t2_tx_cnt", bus.tx_cnt, 5);
    step();
    chk("t2_single_pulse", bus.out_valid, 0);

    // 3: send on VC1 and credit return on VC1 in the same cycle
    bus.src_valid = 1'b1; bus.src_vc = 1'b1;
    bus.src_data = 20'h201; step();
    bus.src_data = 20'h202; step();
    bus.src_valid = 1'b0;
    step(); step(); step();
    chk("t3_cred1_two", dut.cred_q[1], 2);
    chk("t3_tx_cnt_pre", bus.tx_cnt, 7);
    bus.src_valid = 1'b1; bus.src_data = 20'h203; step();
    bus.src_valid = 1'b0; bus.ci = 2'b10; step();
    bus.ci = 2'b00;
    chk("t3_out_valid", bus.out_valid, 1);
    chk("t3_dataout", bus.dataout, 20'h203);
    chk("t3_out_vc", bus.out_vc, 1);
    chk("t3_cred1_hold", dut.cred_q[1], 2);
    chk("t3_no_err", bus.err_credit, 0);
    chk("t3_tx_cnt", bus.tx_cnt, 8);

    // 4: credit returned when already full
    bus.ci = 2'b01;
    step(); step(); step(); step();
    bus.ci = 2'b00;
    chk("t4_cred0_full", dut.cred_q[0], 4);
    chk("t4_err_clear", bus.err_credit, 0);
    bus.ci = 2'b01; step(); bus.ci = 2'b00;
    chk("t4_cred0_capped", dut.cred_q[0], 4);
    chk("t4_err_set", bus.err_credit, 1);
    step(); step(); step();
    chk("t4_err_sticky", bus.err_credit, 1);

    // 5: fill RX FIFO, overflow, then pops generating co
    bus.sink_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.datain   = 20'h300 + 20'(i);
      bus.in_vc    = ((i % 2) == 0);
      step();
    end
    chk("t5_sink_valid", bus.sink_valid, 1);
    chk("t5_sink_data", bus.sink_data, 20'h300);
    chk("t5_sink_vc", bus.sink_vc, 1);
    chk("t5_rx_cnt8", bus.rx_cnt, 8);
    chk("t5_no_ovf", bus.err_ovf, 0);
    bus.datain = 20'h3FF; step();
    bus.in_valid = 1'b0;
    chk("t5_ovf", bus.err_ovf, 1);
    chk("t5_rx_cnt_drop", bus.rx_cnt, 8);
    chk("t5_co_idle", bus.co, 0);
    bus.sink_ready = 1'b1; step(); bus.sink_ready = 1'b0;
    chk("t5_co_vc1", bus.co, 2'b10);
    chk("t5_next_head", bus.sink_data, 20'h301);
    chk("t5_next_vc", bus.sink_vc, 0);
    step();
    chk("t5_co_pulse", bus.co, 0);
    bus.in_valid = 1'b1; bus.datain = 20'h308; bus.in_vc = 1'b0; step();
    bus.datain = 20'h309; bus.in_vc = 1'b1; bus.sink_ready = 1'b1; step();
    bus.in_valid = 1'b0; bus.sink_ready = 1'b0;
    chk("t5_full_pushpop_cnt", bus.rx_cnt, 10);
    chk("t5_co_vc0", bus.co, 2'b01);
    chk("t5_head_after", bus.sink_data, 20'h302);
    chk("t5_ovf_sticky", bus.err_ovf, 1);

    // 6: reset in the middle of an injection burst
    bus.src_valid = 1'b1; bus.src_vc = 1'b0; bus.src_data = 20'h400;
    step(); step();
    RST = 1'b1; step();
    RST = 1'b0; bus.src_valid = 1'b0;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_dataout", bus.dataout, 0);
    chk("t6_tx_cnt", bus.tx_cnt, 0);
    chk("t6_rx_cnt", bus.rx_cnt, 0);
    chk("t6_errs", {bus.err_credit, bus.err_ovf}, 0);
    chk("t6_sink", {bus.sink_valid, bus.sink_data}, 0);
    chk("t6_src_ready", bus.src_ready, 1);
    chk("t6_cred", {dut.cred_q[1], dut.cred_q[0]}, {3'd4, 3'd4});
    step();
    chk("t6_no_inflight", bus.out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
